// File: rtl/ppu_data_port_ctrl_pkg.sv
// Shared constants and types for the PPU CPU-side data port: register selects,
// data-port FSM states and palette address map.
package ppu_data_port_ctrl_pkg;

  localparam logic [2:0] RS_STATUS = 3'd2;
  localparam logic [2:0] RS_SCROLL = 3'd5;
  localparam logic [2:0] RS_ADDR   = 3'd6;
  localparam logic [2:0] RS_DATA   = 3'd7;

  localparam logic [13:0] PAL_BASE_DEF    = 14'h3F00;
  // Palette reads also fetch the nametable byte hidden underneath.
  localparam logic [13:0] PAL_MIRROR_MASK = 14'h2FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACC  = 2'd2
  } dport_state_e;

endpackage

// File: rtl/ppu_data_port_ctrl_addr_incr.sv
// VRAM address post-increment: +1 or +32, wrapping at the address width.
module ppu_addr_incr
  import ppu_data_port_ctrl_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [W-1:0] addr,
  input  logic         inc32,
  output logic [W-1:0] addr_nxt
);

  assign addr_nxt = addr + (inc32 ? W'(32) : W'(1));

endmodule

// File: rtl/ppu_data_port_ctrl.sv
// CPU-side PPU data port: $2002/$2005/$2006/$2007 sequencing, shared write
// toggle, VRAM address register, $2007 read buffer and VRAM bus handshake.
module ppu_data_port_ctrl
  import ppu_data_port_ctrl_pkg::*;
#(
  parameter int              ADDR_W   = 14,
  parameter logic [ADDR_W-1:0] PAL_BASE = ADDR_W'(PAL_BASE_DEF)
) (
  input  logic              PCLK,
  input  logic              n_RES,
  input  logic              acc_stb,
  input  logic [2:0]        RS,
  input  logic              RnW,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              I_1_32,
  input  logic              render_busy,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata,
  input  logic [7:0]        pal_rdata,
  output logic              scroll_wr_first,
  output logic              scroll_wr_second,
  output logic [7:0]        scroll_data,
  output logic              toggle,
  output logic              overrun
);

  dport_state_e state_q, state_d;

  logic              toggle_q, toggle_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [ADDR_W-9:0] temp_hi_q, temp_hi_d;
  logic [7:0]        rd_buf_q, rd_buf_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic              scr_first_q, scr_first_d, scr_second_q, scr_second_d;
  logic [7:0]        scroll_data_q, scroll_data_d;
  logic              overrun_q, overrun_d;

  logic status_rd, scroll_wr, addr_wr, data_acc, accept, done, in_pal;

  assign status_rd = acc_stb & (RS == RS_STATUS) & RnW;
  assign scroll_wr = acc_stb & (RS == RS_SCROLL) & ~RnW;
  assign addr_wr   = acc_stb & (RS == RS_ADDR) & ~RnW;
  assign data_acc  = acc_stb & (RS == RS_DATA);
  assign accept    = data_acc & (state_q == ST_IDLE);
  assign done      = (state_q == ST_ACC) & vram_ack;
  assign in_pal    = (addr_q >= PAL_BASE);

  ppu_addr_incr #(.W(ADDR_W)) u_incr (
    .addr     (addr_q),
    .inc32    (I_1_32),
    .addr_nxt (addr_inc)
  );

  always_ff @(posedge PCLK or negedge n_RES) begin
    if (!n_RES) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (data_acc)     state_d = ST_PEND;
      ST_PEND: if (!render_busy) state_d = ST_ACC;
      ST_ACC:  if (vram_ack)     state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Request comes straight off the state flop so reset withdraws it at once.
  always_comb begin
    vram_req = (state_q == ST_ACC);
  end

  always_comb begin
    toggle_d      = toggle_q;
    addr_d        = addr_q;
    temp_hi_d     = temp_hi_q;
    rd_buf_d      = rd_buf_q;
    cpu_dout_d    = cpu_dout_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    vaddr_d       = vaddr_q;
    scr_first_d   = scroll_wr & ~toggle_q;
    scr_second_d  = scroll_wr & toggle_q;
    scroll_data_d = scroll_wr ? cpu_din : scroll_data_q;
    overrun_d     = overrun_q | (data_acc & (state_q != ST_IDLE));

    if (status_rd)                 toggle_d = 1'b0;
    else if (scroll_wr | addr_wr)  toggle_d = ~toggle_q;

    if (done) begin
      addr_d = addr_inc;
      if (!we_q) rd_buf_d = vram_rdata;
    end

    // A $2006 pair mid-access retargets addr; the in-flight vram_addr is latched.
    if (addr_wr) begin
      if (!toggle_q) temp_hi_d = cpu_din[ADDR_W-9:0];
      else           addr_d    = {temp_hi_q, cpu_din};
    end

    if (accept) begin
      we_d = ~RnW;
      if (!RnW) begin
        wdata_d = cpu_din;
        vaddr_d = addr_q;
      end else begin
        vaddr_d    = in_pal ? (addr_q & ADDR_W'(PAL_MIRROR_MASK)) : addr_q;
        cpu_dout_d = in_pal ? pal_rdata : rd_buf_q;
      end
    end
  end

  always_ff @(posedge PCLK or negedge n_RES) begin
    if (!n_RES) begin
      toggle_q      <= 1'b0;
      addr_q        <= '0;
      temp_hi_q     <= '0;
      rd_buf_q      <= '0;
      cpu_dout_q    <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      vaddr_q       <= '0;
      scr_first_q   <= 1'b0;
      scr_second_q  <= 1'b0;
      scroll_data_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      toggle_q      <= toggle_d;
      addr_q        <= addr_d;
      temp_hi_q     <= temp_hi_d;
      rd_buf_q      <= rd_buf_d;
      cpu_dout_q    <= cpu_dout_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      vaddr_q       <= vaddr_d;
      scr_first_q   <= scr_first_d;
      scr_second_q  <= scr_second_d;
      scroll_data_q <= scroll_data_d;
      overrun_q     <= overrun_d;
    end
  end

  assign cpu_dout         = cpu_dout_q;
  assign vram_we          = we_q;
  assign vram_addr        = vaddr_q;
  assign vram_wdata       = wdata_q;
  assign scroll_wr_first  = scr_first_q;
  assign scroll_wr_second = scr_second_q;
  assign scroll_data      = scroll_data_q;
  assign toggle           = toggle_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_ppu_data_port_ctrl.sv
// Bench for ppu_data_port_ctrl: directed register/data-port scenarios plus a
// randomized op stream against a register-level model and a VRAM responder.
module tb_ppu_data_port_ctrl;
  import ppu_data_port_ctrl_pkg::*;

  logic        PCLK = 1'b0, n_RES = 1'b0, acc_stb = 1'b0;
  logic [2:0]  RS = 3'd0;
  logic        RnW = 1'b1;
  logic [7:0]  cpu_din = 8'h00, cpu_dout;
  logic        I_1_32 = 1'b0, render_busy = 1'b0;
  logic        vram_req, vram_we, vram_ack = 1'b0;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata = 8'h00, pal_rdata = 8'h00;
  logic        scroll_wr_first, scroll_wr_second, toggle, overrun;
  logic [7:0]  scroll_data;

  ppu_data_port_ctrl dut (
    .PCLK(PCLK), .n_RES(n_RES), .acc_stb(acc_stb), .RS(RS), .RnW(RnW),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .I_1_32(I_1_32),
    .render_busy(render_busy), .vram_req(vram_req), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
    .vram_rdata(vram_rdata), .pal_rdata(pal_rdata),
    .scroll_wr_first(scroll_wr_first), .scroll_wr_second(scroll_wr_second),
    .scroll_data(scroll_data), .toggle(toggle), .overrun(overrun)
  );

  always #5 PCLK = ~PCLK;

  int n_pass = 0, n_chk = 0;

  // VRAM contents (read-only image) and log of completed bus accesses.
  logic [7:0]  vmem [0:16383];
  int          ack_lat = 1;
  logic [13:0] lg_addr [$];
  logic        lg_we   [$];
  logic [7:0]  lg_data [$];

  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(negedge PCLK);
      vram_ack = 1'b0;
      if (!n_RES || !vram_req) cnt = 0;
      else begin
        cnt++;
        if (cnt >= ack_lat) begin
          cnt = 0;
          vram_ack = 1'b1;
          vram_rdata = vmem[vram_addr];
          lg_addr.push_back(vram_addr);
          lg_we.push_back(vram_we);
          lg_data.push_back(vram_we ? vram_wdata : vram_rdata);
        end
      end
    end
  end

  // Register-level model
  bit          m_tog, m_ovr;
  logic [13:0] m_addr;
  logic [5:0]  m_thi;
  logic [7:0]  m_rdbuf, m_dout, m_sdata;

  task automatic model_reset();
    m_tog = 0; m_ovr = 0; m_addr = '0; m_thi = '0;
    m_rdbuf = '0; m_dout = '0; m_sdata = '0;
  endtask

  task automatic strobe(input logic [2:0] rs, input logic rnw, input logic [7:0] d);
    acc_stb = 1'b1; RS = rs; RnW = rnw; cpu_din = d;
    @(posedge PCLK); #1;
    acc_stb = 1'b0; cpu_din = 8'($urandom);
  endtask

  task automatic op_reg(input logic [2:0] rs, input logic rnw, input logic [7:0] d);
    bit ef, es;
    ef = 0; es = 0;
    if (rs == RS_STATUS && rnw) m_tog = 0;
    else if (rs == RS_SCROLL && !rnw) begin
      ef = !m_tog; es = m_tog; m_sdata = d; m_tog = !m_tog;
    end else if (rs == RS_ADDR && !rnw) begin
      if (!m_tog) m_thi = d[5:0];
      else        m_addr = {m_thi, d};
      m_tog = !m_tog;
    end
    strobe(rs, rnw, d);
    n_chk++; if (toggle !== m_tog) $display("FAIL toggle rs=%0d: got %b exp %b", rs, toggle, m_tog); else n_pass++;
    n_chk++; if ({scroll_wr_first, scroll_wr_second} !== {ef, es})
      $display("FAIL scroll_pulse rs=%0d: got %b%b exp %b%b", rs, scroll_wr_first, scroll_wr_second, ef, es); else n_pass++;
    n_chk++; if (scroll_data !== m_sdata) $display("FAIL scroll_data: got %h exp %h", scroll_data, m_sdata); else n_pass++;
    n_chk++; if (cpu_dout !== m_dout) $display("FAIL dout_hold: got %h exp %h", cpu_dout, m_dout); else n_pass++;
    n_chk++; if (overrun !== m_ovr) $display("FAIL overrun: got %b exp %b", overrun, m_ovr); else n_pass++;
    n_chk++; if (vram_req !== 1'b0) $display("FAIL req_idle: got %b exp 0", vram_req); else n_pass++;
  endtask

  task automatic set_addr(input logic [13:0] a);
    op_reg(RS_ADDR, 1'b0, {2'($urandom), a[13:8]});
    op_reg(RS_ADDR, 1'b0, a[7:0]);
  endtask

  task automatic do_data(input logic rnw, input logic [7:0] d, input int busy, input int lat);
    logic [13:0] ev;
    bit pal, got;
    int nlog;
    pal = (m_addr >= 14'h3F00);
    ev  = (rnw && pal) ? (m_addr & 14'h2FFF) : m_addr;
    if (rnw) m_dout = pal ? pal_rdata : m_rdbuf;
    ack_lat = lat; render_busy = (busy > 0); nlog = lg_addr.size();
    strobe(RS_DATA, rnw, d);
    n_chk++; if (cpu_dout !== m_dout) $display("FAIL dout: got %h exp %h", cpu_dout, m_dout); else n_pass++;
    n_chk++; if (toggle !== m_tog) $display("FAIL toggle_data: got %b exp %b", toggle, m_tog); else n_pass++;
    for (int k = 0; k < busy; k++) begin
      n_chk++; if (vram_req !== 1'b0) $display("FAIL req_busy: got %b exp 0", vram_req); else n_pass++;
      @(posedge PCLK); #1;
    end
    render_busy = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge PCLK); #1;
      if (lg_addr.size() > nlog) got = 1;
    end
    n_chk++; if (!got) $display("FAIL access_timeout: got none exp 1 access"); else n_pass++;
    if (got) begin
      n_chk++; if (lg_addr[nlog] !== ev) $display("FAIL vram_addr: got %h exp %h", lg_addr[nlog], ev); else n_pass++;
      n_chk++; if (lg_we[nlog] !== !rnw) $display("FAIL vram_we: got %b exp %b", lg_we[nlog], !rnw); else n_pass++;
      if (!rnw) begin
        n_chk++; if (lg_data[nlog] !== d) $display("FAIL vram_wdata: got %h exp %h", lg_data[nlog], d); else n_pass++;
      end else m_rdbuf = vmem[ev];
      m_addr = m_addr + (I_1_32 ? 14'd32 : 14'd1);
      n_chk++; if (vram_req !== 1'b0) $display("FAIL req_after_ack: got %b exp 0", vram_req); else n_pass++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge PCLK);
    #1;
    n_chk++; if ({cpu_dout, vram_req, vram_we, vram_addr, vram_wdata} !== '0)
      $display("FAIL reset_bus: got %h/%b/%b/%h/%h exp all 0", cpu_dout, vram_req, vram_we, vram_addr, vram_wdata); else n_pass++;
    n_chk++; if ({scroll_wr_first, scroll_wr_second, scroll_data, toggle, overrun} !== '0)
      $display("FAIL reset_regs: got %b%b/%h/%b/%b exp all 0", scroll_wr_first, scroll_wr_second, scroll_data, toggle, overrun); else n_pass++;
    n_RES = 1'b1;
    model_reset();
  endtask

  task automatic test_addr_write();
    op_reg(RS_ADDR, 1'b0, 8'h21);
    n_chk++; if (toggle !== 1'b1) $display("FAIL addr_tog1: got %b exp 1", toggle); else n_pass++;
    op_reg(RS_ADDR, 1'b0, 8'h08);
    n_chk++; if (toggle !== 1'b0) $display("FAIL addr_tog0: got %b exp 0", toggle); else n_pass++;
    do_data(1'b0, 8'h99, 0, 2);
    n_chk++; if (lg_addr[lg_addr.size()-1] !== 14'h2108) $display("FAIL addr_2108: got %h exp 2108", lg_addr[lg_addr.size()-1]); else n_pass++;
    op_reg(RS_ADDR, 1'b0, 8'h3F);
    op_reg(RS_STATUS, 1'b1, 8'h00);
    op_reg(RS_ADDR, 1'b0, 8'h24);
    op_reg(RS_ADDR, 1'b0, 8'h00);
  endtask

  task automatic test_read_inc32();
    I_1_32 = 1'b1;
    do_data(1'b1, 8'h00, 0, 1);
    n_chk++; if (cpu_dout !== 8'h00) $display("FAIL rd_stale: got %h exp 00", cpu_dout); else n_pass++;
    n_chk++; if (lg_addr[lg_addr.size()-1] !== 14'h2400) $display("FAIL rd_addr0: got %h exp 2400", lg_addr[lg_addr.size()-1]); else n_pass++;
    do_data(1'b1, 8'h00, 0, 2);
    n_chk++; if (cpu_dout !== 8'h11) $display("FAIL rd_second: got %h exp 11", cpu_dout); else n_pass++;
    n_chk++; if (lg_addr[lg_addr.size()-1] !== 14'h2420) $display("FAIL rd_addr1: got %h exp 2420", lg_addr[lg_addr.size()-1]); else n_pass++;
    do_data(1'b0, 8'h33, 0, 1);
    n_chk++; if (lg_addr[lg_addr.size()-1] !== 14'h2440) $display("FAIL rd_addr2: got %h exp 2440", lg_addr[lg_addr.size()-1]); else n_pass++;
    I_1_32 = 1'b0;
  endtask

  task automatic test_data_write();
    set_addr(14'h2000);
    do_data(1'b0, 8'h5A, 0, 3);
    n_chk++; if ({lg_addr[lg_addr.size()-1], lg_data[lg_data.size()-1]} !== {14'h2000, 8'h5A})
      $display("FAIL wr_2000: got %h/%h exp 2000/5a", lg_addr[lg_addr.size()-1], lg_data[lg_data.size()-1]); else n_pass++;
    do_data(1'b0, 8'h5B, 0, 1);
    n_chk++; if (lg_addr[lg_addr.size()-1] !== 14'h2001) $display("FAIL wr_2001: got %h exp 2001", lg_addr[lg_addr.size()-1]); else n_pass++;
  endtask

  task automatic test_palette();
    set_addr(14'h3F05);
    pal_rdata = 8'h2C;
    do_data(1'b1, 8'h00, 0, 1);
    n_chk++; if (cpu_dout !== 8'h2C) $display("FAIL pal_dout: got %h exp 2c", cpu_dout); else n_pass++;
    n_chk++; if (lg_addr[lg_addr.size()-1] !== 14'h2F05) $display("FAIL pal_fetch: got %h exp 2f05", lg_addr[lg_addr.size()-1]); else n_pass++;
    set_addr(14'h0000);
    pal_rdata = 8'hFF;
    do_data(1'b1, 8'h00, 0, 1);
    n_chk++; if (cpu_dout !== 8'hA7) $display("FAIL pal_rdbuf: got %h exp a7", cpu_dout); else n_pass++;
  endtask

  task automatic test_wrap();
    set_addr(14'h3FFF);
    do_data(1'b0, 8'h01, 0, 1);
    do_data(1'b0, 8'h02, 0, 1);
    n_chk++; if (lg_addr[lg_addr.size()-1] !== 14'h0000) $display("FAIL wrap1: got %h exp 0000", lg_addr[lg_addr.size()-1]); else n_pass++;
    set_addr(14'h3FF0);
    I_1_32 = 1'b1;
    do_data(1'b0, 8'h03, 0, 1);
    do_data(1'b0, 8'h04, 0, 1);
    n_chk++; if (lg_addr[lg_addr.size()-1] !== 14'h0010) $display("FAIL wrap32: got %h exp 0010", lg_addr[lg_addr.size()-1]); else n_pass++;
    I_1_32 = 1'b0;
  endtask

  task automatic test_busy_overrun();
    int nlog;
    bit got;
    set_addr(14'h2800);
    m_dout = m_rdbuf;
    render_busy = 1'b1; ack_lat = 1; nlog = lg_addr.size();
    strobe(RS_DATA, 1'b1, 8'h00);
    for (int k = 0; k < 10; k++) begin
      n_chk++; if (vram_req !== 1'b0) $display("FAIL busy_req k=%0d: got %b exp 0", k, vram_req); else n_pass++;
      if (k == 3) strobe(RS_DATA, 1'b0, 8'hEE);
      else begin @(posedge PCLK); #1; end
    end
    m_ovr = 1;
    n_chk++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b exp 1", overrun); else n_pass++;
    n_chk++; if (cpu_dout !== m_dout) $display("FAIL busy_dout: got %h exp %h", cpu_dout, m_dout); else n_pass++;
    render_busy = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge PCLK); #1;
      if (lg_addr.size() > nlog) got = 1;
    end
    repeat (5) @(posedge PCLK);
    #1;
    n_chk++; if (lg_addr.size() !== nlog + 1) $display("FAIL busy_single: got %0d exp 1 access", lg_addr.size() - nlog); else n_pass++;
    if (lg_addr.size() > nlog) begin
      n_chk++; if ({lg_addr[nlog], lg_we[nlog]} !== {14'h2800, 1'b0})
        $display("FAIL busy_acc: got %h/%b exp 2800/0", lg_addr[nlog], lg_we[nlog]); else n_pass++;
    end
    m_rdbuf = vmem[14'h2800];
    m_addr  = 14'h2801;
    n_chk++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b exp 1", overrun); else n_pass++;
  endtask

  task automatic test_scroll();
    op_reg(RS_SCROLL, 1'b0, 8'h12);
    @(posedge PCLK); #1;
    n_chk++; if ({scroll_wr_first, scroll_wr_second} !== 2'b00) $display("FAIL scroll_one_cycle: got %b%b exp 00", scroll_wr_first, scroll_wr_second); else n_pass++;
    op_reg(RS_SCROLL, 1'b0, 8'h34);
  endtask

  task automatic test_random();
    logic [13:0] a;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: op_reg(RS_STATUS, 1'b1, 8'($urandom));
        1, 2: op_reg(RS_SCROLL, 1'b0, 8'($urandom));
        3: op_reg(RS_ADDR, 1'b0, 8'($urandom));
        4: begin
          case ($urandom_range(0, 4))
            0: a = 14'h3FFF;
            1: a = 14'h3FF0;
            2: a = 14'h3F00 | 14'($urandom_range(0, 31));
            3: a = 14'h2000 | 14'($urandom_range(0, 1023));
            default: a = 14'($urandom);
          endcase
          set_addr(a);
        end
        5, 6, 7: begin
          I_1_32 = 1'($urandom); pal_rdata = 8'($urandom);
          do_data(1'($urandom_range(0, 2) != 0), 8'($urandom), $urandom_range(0, 3), $urandom_range(1, 4));
        end
        8: op_reg(3'($urandom_range(0, 1) * 3 + $urandom_range(0, 1)), 1'($urandom), 8'($urandom));
        default: case ($urandom_range(0, 2))
          0: op_reg(RS_STATUS, 1'b0, 8'($urandom));
          1: op_reg(RS_SCROLL, 1'b1, 8'($urandom));
          default: op_reg(RS_ADDR, 1'b1, 8'($urandom));
        endcase
      endcase
    end
  endtask

  task automatic test_reset_mid();
    int nlog;
    set_addr(14'h1234);
    ack_lat = 30; nlog = lg_addr.size();
    strobe(RS_DATA, 1'b0, 8'h77);
    for (int k = 0; k < 5 && !vram_req; k++) begin @(posedge PCLK); #1; end
    n_chk++; if (vram_req !== 1'b1) $display("FAIL mid_req_up: got %b exp 1", vram_req); else n_pass++;
    #2; n_RES = 1'b0; #1;
    n_chk++; if (vram_req !== 1'b0) $display("FAIL mid_req_async: got %b exp 0", vram_req); else n_pass++;
    n_chk++; if ({cpu_dout, vram_we, vram_addr, vram_wdata, scroll_wr_first, scroll_wr_second, scroll_data, toggle, overrun} !== '0)
      $display("FAIL mid_reset_vals: got %h/%b/%h/%h/%h/%b/%b exp all 0", cpu_dout, vram_we, vram_addr, vram_wdata, scroll_data, toggle, overrun); else n_pass++;
    @(posedge PCLK); #1;
    n_RES = 1'b1;
    model_reset();
    repeat (4) @(posedge PCLK);
    #1;
    n_chk++; if (lg_addr.size() !== nlog || vram_req !== 1'b0)
      $display("FAIL mid_abandon: got %0d accesses req=%b exp 0/0", lg_addr.size() - nlog, vram_req); else n_pass++;
    ack_lat = 1;
    do_data(1'b1, 8'h00, 0, 1);
    n_chk++; if (cpu_dout !== 8'h00) $display("FAIL post_reset_rdbuf: got %h exp 00", cpu_dout); else n_pass++;
    n_chk++; if (lg_addr[lg_addr.size()-1] !== 14'h0000) $display("FAIL post_reset_addr: got %h exp 0000", lg_addr[lg_addr.size()-1]); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vmem[i] = 8'($urandom);
    vmem[14'h2400] = 8'h11;
    vmem[14'h2420] = 8'h22;
    vmem[14'h2F05] = 8'hA7;
    model_reset();
    test_reset();
    test_addr_write();
    test_read_inc32();
    test_data_write();
    test_palette();
    test_wrap();
    test_scroll();
    test_busy_overrun();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
